act_mem_reader: RTL

Streams a range of activation-memory entries out of an `act_memory` instance, one DATA_SIZE word per beat, with a valid/ready output handshake. The block owns the memory's read-index ports: it walks entry, then y, then x, and registers each combinationally-read word into an output stage. It sits between an activation memory and the next layer's compute or dump logic. It is the read-side counterpart of the memory's write path.

---
 rtl/act_mem_reader_if.sv | 33 +++
 rtl/act_mem_reader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/act_mem_reader_if.sv
// Output beat stream of the activation-memory reader.
// Payload is a memory word tagged with its entry/y/x indices.
interface act_mem_reader_if #(
  parameter int DATA_SIZE = 64
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic [15:0]          out_entry;
  logic [15:0]          out_y;
  logic [15:0]          out_x;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_entry,
    output out_y,
    output out_x,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_entry,
    input  out_y,
    input  out_x,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/act_mem_reader.sv
// Streams entry ranges out of an activation memory.
// Walks x, then y, then entry; one registered word per beat.
module act_mem_reader #(
  parameter int ENTRY_NUM = 16,
  parameter int DIM       = 1,
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          entry_base,
  input  logic [15:0]          entry_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          read_index_entry,
  output logic [15:0]          read_index_y,
  output logic [15:0]          read_index_x,
  input  logic [DATA_SIZE-1:0] mem_data,
  act_mem_reader_if.master     ob
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [15:0] DMAX = 16'(DIM - 1);
  localparam logic [16:0] ELIM = 17'(ENTRY_NUM);

  state_t      state;
  logic [15:0] last_entry;
  logic [16:0] req_end;
  logic        free;
  logic        x_end;
  logic        y_end;
  logic        at_last;

  assign req_end = {1'b0, entry_base} + {1'b0, entry_count};
  assign free    = !ob.out_valid || ob.out_ready;
  assign x_end   = read_index_x == DMAX;
  assign y_end   = read_index_y == DMAX;
  assign at_last = x_end && y_end &&
                   read_index_entry == last_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      last_entry       <= '0;
      read_index_entry <= '0;
      read_index_y     <= '0;
      read_index_x     <= '0;
      ob.out_valid     <= 1'b0;
      ob.out_last      <= 1'b0;
      ob.out_data      <= '0;
      ob.out_entry     <= '0;
      ob.out_y         <= '0;
      ob.out_x         <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (entry_count == '0) begin
              done <= 1'b1;
            end else if (req_end > ELIM) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state            <= RUN;
              busy             <= 1'b1;
              last_entry       <= entry_base + entry_count - 16'd1;
              read_index_entry <= entry_base;
              read_index_y     <= '0;
              read_index_x     <= '0;
            end
          end
        end
        RUN: begin
          if (free) begin
            ob.out_valid <= 1'b1;
            ob.out_last  <= at_last;
            ob.out_data  <= mem_data;
            ob.out_entry <= read_index_entry;
            ob.out_y     <= read_index_y;
            ob.out_x     <= read_index_x;
            // Indices freeze on the final word; DRAIN only waits for accept.
            if (at_last) begin
              state <= DRAIN;
            end else if (!x_end) begin
              read_index_x <= read_index_x + 16'd1;
            end else begin
              read_index_x <= '0;
              if (!y_end) begin
                read_index_y <= read_index_y + 16'd1;
              end else begin
                read_index_y     <= '0;
                read_index_entry <= read_index_entry + 16'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (ob.out_valid && ob.out_ready) begin
            ob.out_valid <= 1'b0;
            ob.out_last  <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
